// File: rtl/mem_arbiter_if.sv
// Bundle of client-side and memory-side signals around the line-granular memory arbiter.
// master: the arbiter's view; slave: the caches/memory environment's view.
interface mem_arbiter_if;
  // icache client
  logic         ic_req_en;
  logic [19:0]  ic_req_addr;
  logic         ic_ack;
  logic         ic_rsp_en;
  logic [127:0] ic_rsp_line;
  // dcache client
  logic         dc_rd_en;
  logic [19:0]  dc_rd_addr;
  logic         dc_wb_en;
  logic [19:0]  dc_wb_addr;
  logic [127:0] dc_wb_line;
  logic         dc_ack;
  logic         dc_rsp_en;
  logic [127:0] dc_rsp_line;
  // memory port
  logic         mem_ren;
  logic [19:0]  mem_raddr;
  logic         mem_wen;
  logic [19:0]  mem_waddr;
  logic [127:0] mem_wline;
  logic         mem_rec_en;
  logic [19:0]  mem_rec_addr;
  logic [127:0] mem_rec_line;

  modport master (
    input  ic_req_en, ic_req_addr,
    output ic_ack, ic_rsp_en, ic_rsp_line,
    input  dc_rd_en, dc_rd_addr, dc_wb_en, dc_wb_addr, dc_wb_line,
    output dc_ack, dc_rsp_en, dc_rsp_line,
    output mem_ren, mem_raddr, mem_wen, mem_waddr, mem_wline,
    input  mem_rec_en, mem_rec_addr, mem_rec_line
  );

  modport slave (
    output ic_req_en, ic_req_addr,
    input  ic_ack, ic_rsp_en, ic_rsp_line,
    output dc_rd_en, dc_rd_addr, dc_wb_en, dc_wb_addr, dc_wb_line,
    input  dc_ack, dc_rsp_en, dc_rsp_line,
    input  mem_ren, mem_raddr, mem_wen, mem_waddr, mem_wline,
    output mem_rec_en, mem_rec_addr, mem_rec_line
  );
endinterface

// File: rtl/mem_arbiter.sv
// Memory-port initiator: arbitrates icache fills, dcache fills and dcache writebacks,
// keeps one transaction in flight, enforces a minimum read latency and routes the
// returned line to the winning cache.
module mem_arbiter #(
  parameter int LATENCY = 5,
  parameter int TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.master bus,
  output logic         busy,
  output logic         err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  // cnt is 0 in the first WAIT cycle, so leaving WAIT at cnt == N-2 puts
  // rsp_en exactly N cycles after mem_ren (used for both latency and timeout).
  localparam logic [7:0]  LAT_EXIT  = 8'(LATENCY - 2);
  localparam logic [7:0]  TO_EXIT   = 8'(TIMEOUT - 2);
  localparam logic [19:0] LINE_MASK = 20'hFFFF0;

  logic [2:0]   state_q, state_d;
  logic         last_dc_q, last_dc_d;   // 1: dcache got the previous grant
  logic         gnt_dc_q, gnt_dc_d;     // 1: current transaction belongs to dcache
  logic         first_q, first_d;       // first cycle after grant (ack cycle)
  logic         rd_q, rd_d;             // transaction includes a read
  logic [7:0]   cnt_q, cnt_d;
  logic         got_q, got_d;           // matching response captured
  logic         err_q, err_d;
  logic [19:0]  raddr_q, raddr_d;
  logic [19:0]  waddr_q, waddr_d;
  logic [127:0] wline_q, wline_d;
  logic [127:0] cap_q, cap_d;
  logic [127:0] ic_line_q, ic_line_d;
  logic [127:0] dc_line_q, dc_line_d;

  logic         ic_pend, dc_pend, pick_ic, match, have_line;
  logic [127:0] line_now;

  // Next-state, grant and response-capture logic
  always_comb begin
    state_d   = state_q;
    last_dc_d = last_dc_q;
    gnt_dc_d  = gnt_dc_q;
    first_d   = 1'b0;
    rd_d      = rd_q;
    cnt_d     = cnt_q;
    got_d     = got_q;
    err_d     = err_q;
    raddr_d   = raddr_q;
    waddr_d   = waddr_q;
    wline_d   = wline_q;
    cap_d     = cap_q;
    ic_line_d = ic_line_q;
    dc_line_d = dc_line_q;

    ic_pend   = bus.ic_req_en;
    dc_pend   = bus.dc_rd_en | bus.dc_wb_en;
    pick_ic   = ic_pend & (~dc_pend | last_dc_q);
    match     = bus.mem_rec_en & (((bus.mem_rec_addr ^ raddr_q) & LINE_MASK) == 20'h0);
    have_line = got_q | match;
    line_now  = got_q ? cap_q : bus.mem_rec_line;

    case (state_q)
      S_IDLE: begin
        if (ic_pend | dc_pend) begin
          gnt_dc_d  = ~pick_ic;
          last_dc_d = ~pick_ic;
          first_d   = 1'b1;
          rd_d      = pick_ic | bus.dc_rd_en;
          raddr_d   = pick_ic ? bus.ic_req_addr : bus.dc_rd_addr;
          waddr_d   = bus.dc_wb_addr;
          wline_d   = bus.dc_wb_line;
          cnt_d     = 8'd0;
          got_d     = 1'b0;
          state_d   = (~pick_ic & bus.dc_wb_en) ? S_WRITE : S_READ;
        end
      end
      S_WRITE: begin
        state_d = rd_q ? S_READ : S_IDLE;
      end
      S_READ: begin
        cnt_d   = 8'd0;
        got_d   = 1'b0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        if (match & ~got_q) begin
          got_d = 1'b1;
          cap_d = bus.mem_rec_line;
        end
        if (have_line & (cnt_q >= LAT_EXIT)) begin
          if (gnt_dc_q) dc_line_d = line_now;
          else          ic_line_d = line_now;
          state_d = S_RESP;
        end else if (~have_line & (cnt_q >= TO_EXIT)) begin
          err_d = 1'b1;
          if (gnt_dc_q) dc_line_d = 128'h0;
          else          ic_line_d = 128'h0;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; control and client-visible lines reset, datapath latches do not
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      last_dc_q <= 1'b1;
      gnt_dc_q  <= 1'b0;
      first_q   <= 1'b0;
      rd_q      <= 1'b0;
      cnt_q     <= 8'd0;
      got_q     <= 1'b0;
      err_q     <= 1'b0;
      ic_line_q <= 128'h0;
      dc_line_q <= 128'h0;
    end else begin
      state_q   <= state_d;
      last_dc_q <= last_dc_d;
      gnt_dc_q  <= gnt_dc_d;
      first_q   <= first_d;
      rd_q      <= rd_d;
      cnt_q     <= cnt_d;
      got_q     <= got_d;
      err_q     <= err_d;
      ic_line_q <= ic_line_d;
      dc_line_q <= dc_line_d;
    end
    raddr_q <= raddr_d;
    waddr_q <= waddr_d;
    wline_q <= wline_d;
    cap_q   <= cap_d;
  end

  assign busy            = (state_q != S_IDLE);
  assign err             = err_q;
  assign bus.ic_ack      = first_q & ~gnt_dc_q;
  assign bus.dc_ack      = first_q & gnt_dc_q;
  assign bus.mem_ren     = (state_q == S_READ);
  assign bus.mem_raddr   = (state_q == S_READ) ? raddr_q : 20'h0;
  assign bus.mem_wen     = (state_q == S_WRITE);
  assign bus.mem_waddr   = (state_q == S_WRITE) ? waddr_q : 20'h0;
  assign bus.mem_wline   = (state_q == S_WRITE) ? wline_q : 128'h0;
  assign bus.ic_rsp_en   = (state_q == S_RESP) & ~gnt_dc_q;
  assign bus.dc_rsp_en   = (state_q == S_RESP) & gnt_dc_q;
  assign bus.ic_rsp_line = ic_line_q;
  assign bus.dc_rsp_line = dc_line_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural memory stub (LATENCY=5, TIMEOUT=16).
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic busy, err;
  int   n_checks = 0;
  int   n_fail = 0;
  int   stub_delay = 1;   // cycles from mem_ren to mem_rec_en
  int   stub_mode = 0;    // 0 normal, 1 drop response, 2 wrong line address
  logic [127:0] mem_store [int];

  mem_arbiter_if bus();

  mem_arbiter #(.LATENCY(5), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .bus(bus), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] dflt(input logic [19:0] a);
    logic [31:0] w;
    w = {16'hC0DE, a[19:4]};
    return {w, w ^ 32'h11111111, w ^ 32'h22222222, w ^ 32'h33333333};
  endfunction

  function automatic logic [127:0] mem_line(input logic [19:0] a);
    if (mem_store.exists(int'(a[19:4]))) return mem_store[int'(a[19:4])];
    return dflt(a);
  endfunction

  // Memory stub: stores writes, answers reads after stub_delay cycles with low address bits scrambled
  initial begin
    int pend;
    logic [19:0] paddr;
    pend = 0;
    paddr = 20'h0;
    bus.mem_rec_en = 1'b0;
    bus.mem_rec_addr = 20'h0;
    bus.mem_rec_line = 128'h0;
    forever begin
      @(negedge clk);
      bus.mem_rec_en = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          bus.mem_rec_en = 1'b1;
          bus.mem_rec_addr = {paddr[19:4], ~paddr[3:0]};
          bus.mem_rec_line = mem_line(paddr);
        end
      end
      if (bus.mem_wen) mem_store[int'(bus.mem_waddr[19:4])] = bus.mem_wline;
      if (bus.mem_ren && stub_mode != 1) begin
        pend = stub_delay;
        paddr = (stub_mode == 2) ? (bus.mem_raddr ^ 20'h00100) : bus.mem_raddr;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic clear_inputs;
    bus.ic_req_en = 1'b0; bus.ic_req_addr = 20'h0;
    bus.dc_rd_en = 1'b0;  bus.dc_rd_addr = 20'h0;
    bus.dc_wb_en = 1'b0;  bus.dc_wb_addr = 20'h0; bus.dc_wb_line = 128'h0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Single icache read from an idle arbiter, checked cycle by cycle (request in cycle 0)
  task automatic run_read_ic(input logic [19:0] a, input string tag);
    bus.ic_req_en = 1'b1; bus.ic_req_addr = a;
    @(negedge clk);
    n_checks++;
    if ({bus.ic_ack, bus.mem_ren, bus.mem_wen, bus.dc_ack} !== 4'b1100) begin
      n_fail++; $display("FAIL %s_grant: ic_ack/ren/wen/dc_ack=%b expected 1100", tag, {bus.ic_ack, bus.mem_ren, bus.mem_wen, bus.dc_ack});
    end
    n_checks++;
    if (bus.mem_raddr !== a) begin n_fail++; $display("FAIL %s_raddr: got %h expected %h", tag, bus.mem_raddr, a); end
    bus.ic_req_en = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    if (bus.ic_rsp_en !== 1'b0) begin n_fail++; $display("FAIL %s_early: ic_rsp_en=%b at cycle 5 expected 0", tag, bus.ic_rsp_en); end
    @(negedge clk);
    n_checks++;
    if ({bus.ic_rsp_en, bus.dc_rsp_en} !== 2'b10) begin
      n_fail++; $display("FAIL %s_rsp: ic/dc rsp_en=%b expected 10", tag, {bus.ic_rsp_en, bus.dc_rsp_en});
    end
    n_checks++;
    if (bus.ic_rsp_line !== mem_line(a)) begin n_fail++; $display("FAIL %s_line: got %h expected %h", tag, bus.ic_rsp_line, mem_line(a)); end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL %s_idle: busy=%b expected 0", tag, busy); end
  endtask

  task automatic test_reset;
    do_reset();
    n_checks++;
    if ({busy, err, bus.ic_ack, bus.dc_ack, bus.ic_rsp_en, bus.dc_rsp_en, bus.mem_ren, bus.mem_wen} !== 8'h00) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 00000000", {busy, err, bus.ic_ack, bus.dc_ack, bus.ic_rsp_en, bus.dc_rsp_en, bus.mem_ren, bus.mem_wen});
    end
    n_checks++;
    if ({bus.mem_raddr, bus.mem_waddr, bus.mem_wline, bus.ic_rsp_line, bus.dc_rsp_line} !== 424'h0) begin
      n_fail++; $display("FAIL reset_data: got %h expected 0", {bus.mem_raddr, bus.mem_waddr, bus.mem_wline, bus.ic_rsp_line, bus.dc_rsp_line});
    end
  endtask

  task automatic test_basic;
    run_read_ic(20'h01230, "t1");
  endtask

  task automatic test_round_robin;
    logic exp_dc, got;
    logic [19:0] ia, da;
    do_reset();
    ia = 20'h10000; da = 20'h20010;
    bus.ic_req_addr = ia; bus.dc_rd_addr = da;
    bus.ic_req_en = 1'b1; bus.dc_rd_en = 1'b1;
    exp_dc = 1'b0;
    for (int i = 0; i < 101; i++) begin
      got = 1'b0;
      for (int k = 0; k < 40 && !got; k++) begin @(negedge clk); got = bus.ic_ack | bus.dc_ack; end
      n_checks++;
      if (!got || bus.dc_ack !== exp_dc || bus.ic_ack !== !exp_dc) begin
        n_fail++; $display("FAIL rr_grant%0d: ic_ack=%b dc_ack=%b expected dc_ack=%b", i, bus.ic_ack, bus.dc_ack, exp_dc);
      end
      if (!got) break;
      if (exp_dc) bus.dc_rd_en = 1'b0; else bus.ic_req_en = 1'b0;
      got = 1'b0;
      for (int k = 0; k < 40 && !got; k++) begin @(negedge clk); got = exp_dc ? bus.dc_rsp_en : bus.ic_rsp_en; end
      n_checks++;
      if (!got || (exp_dc ? bus.dc_rsp_line : bus.ic_rsp_line) !== mem_line(exp_dc ? da : ia)) begin
        n_fail++; $display("FAIL rr_rsp%0d: rsp seen=%b line ic=%h dc=%h", i, got, bus.ic_rsp_line, bus.dc_rsp_line);
      end
      if (!got) break;
      if (i < 99) begin
        if (exp_dc) bus.dc_rd_en = 1'b1; else bus.ic_req_en = 1'b1;
      end
      exp_dc = !exp_dc;
    end
    clear_inputs();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_wb_rd;
    logic [127:0] lw;
    lw = 128'hDEADBEEF_01234567_89ABCDEF_FEEDF00D;
    bus.dc_wb_en = 1'b1; bus.dc_wb_addr = 20'h0AB00; bus.dc_wb_line = lw;
    bus.dc_rd_en = 1'b1; bus.dc_rd_addr = 20'h01230;
    @(negedge clk);
    n_checks++;
    if ({bus.mem_wen, bus.mem_ren, bus.dc_ack, bus.ic_ack} !== 4'b1010) begin
      n_fail++; $display("FAIL t3_wr: wen/ren/dc_ack/ic_ack=%b expected 1010", {bus.mem_wen, bus.mem_ren, bus.dc_ack, bus.ic_ack});
    end
    n_checks++;
    if ({bus.mem_waddr, bus.mem_wline} !== {20'h0AB00, lw}) begin
      n_fail++; $display("FAIL t3_wdata: waddr=%h wline=%h expected 0ab00 %h", bus.mem_waddr, bus.mem_wline, lw);
    end
    bus.dc_wb_en = 1'b0; bus.dc_rd_en = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus.mem_ren, bus.mem_wen, bus.dc_ack, bus.mem_raddr} !== {3'b100, 20'h01230}) begin
      n_fail++; $display("FAIL t3_rd: ren/wen/ack=%b raddr=%h expected 100 01230", {bus.mem_ren, bus.mem_wen, bus.dc_ack}, bus.mem_raddr);
    end
    repeat (5) @(negedge clk);
    n_checks++;
    if ({bus.dc_rsp_en, bus.ic_rsp_en} !== 2'b10 || bus.dc_rsp_line !== mem_line(20'h01230)) begin
      n_fail++; $display("FAIL t3_rsp: dc/ic rsp_en=%b line=%h expected 10 %h", {bus.dc_rsp_en, bus.ic_rsp_en}, bus.dc_rsp_line, mem_line(20'h01230));
    end
    @(negedge clk);
    bus.dc_rd_en = 1'b1; bus.dc_rd_addr = 20'h0AB00;
    @(negedge clk);
    bus.dc_rd_en = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++;
    if (bus.dc_rsp_en !== 1'b1 || bus.dc_rsp_line !== lw) begin
      n_fail++; $display("FAIL t3_readback: dc_rsp_en=%b line=%h expected 1 %h", bus.dc_rsp_en, bus.dc_rsp_line, lw);
    end
    @(negedge clk);
  endtask

  task automatic test_wb_only;
    bus.dc_wb_en = 1'b1; bus.dc_wb_addr = 20'h00040; bus.dc_wb_line = {4{32'h5A5A0040}};
    @(negedge clk);
    n_checks++;
    if ({bus.mem_wen, bus.dc_ack, bus.mem_ren, bus.mem_waddr} !== {3'b110, 20'h00040}) begin
      n_fail++; $display("FAIL t4_wr: wen/ack/ren=%b waddr=%h expected 110 00040", {bus.mem_wen, bus.dc_ack, bus.mem_ren}, bus.mem_waddr);
    end
    bus.dc_wb_en = 1'b0;
    bus.ic_req_en = 1'b1; bus.ic_req_addr = 20'h00400;
    @(negedge clk);
    n_checks++;
    if ({busy, bus.mem_wen, bus.ic_rsp_en, bus.dc_rsp_en} !== 4'b0000) begin
      n_fail++; $display("FAIL t4_idle: busy/wen/ic_rsp/dc_rsp=%b expected 0000", {busy, bus.mem_wen, bus.ic_rsp_en, bus.dc_rsp_en});
    end
    @(negedge clk);
    n_checks++;
    if ({bus.ic_ack, bus.mem_ren, bus.mem_raddr} !== {2'b11, 20'h00400}) begin
      n_fail++; $display("FAIL t4_next: ic_ack/ren=%b raddr=%h expected 11 00400", {bus.ic_ack, bus.mem_ren}, bus.mem_raddr);
    end
    bus.ic_req_en = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++;
    if (bus.ic_rsp_en !== 1'b1 || bus.ic_rsp_line !== dflt(20'h00400)) begin
      n_fail++; $display("FAIL t4_rsp: ic_rsp_en=%b line=%h expected 1 %h", bus.ic_rsp_en, bus.ic_rsp_line, dflt(20'h00400));
    end
    @(negedge clk);
  endtask

  task automatic test_timeout;
    logic bad;
    stub_mode = 1;
    bus.ic_req_en = 1'b1; bus.ic_req_addr = 20'h02340;
    @(negedge clk);
    bus.ic_req_en = 1'b0;
    bad = 1'b0;
    repeat (15) begin @(negedge clk); bad |= bus.ic_rsp_en | bus.dc_rsp_en | err; end
    n_checks++;
    if (bad !== 1'b0) begin n_fail++; $display("FAIL t5_quiet: rsp_en/err seen=%b before timeout expected 0", bad); end
    @(negedge clk);
    n_checks++;
    if ({bus.ic_rsp_en, err} !== 2'b11 || bus.ic_rsp_line !== 128'h0) begin
      n_fail++; $display("FAIL t5_drop: ic_rsp_en/err=%b line=%h expected 11 0", {bus.ic_rsp_en, err}, bus.ic_rsp_line);
    end
    @(negedge clk);
    stub_mode = 2;
    bus.dc_rd_en = 1'b1; bus.dc_rd_addr = 20'h03000;
    @(negedge clk);
    bus.dc_rd_en = 1'b0;
    repeat (16) @(negedge clk);
    n_checks++;
    if (bus.dc_rsp_en !== 1'b1 || bus.dc_rsp_line !== 128'h0) begin
      n_fail++; $display("FAIL t5_wrongaddr: dc_rsp_en=%b line=%h expected 1 0", bus.dc_rsp_en, bus.dc_rsp_line);
    end
    @(negedge clk);
    stub_mode = 0;
    run_read_ic(20'h04560, "t5_after");
    n_checks++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL t5_sticky: err=%b expected 1", err); end
  endtask

  task automatic test_reset_mid;
    logic bad;
    stub_delay = 6;
    bus.ic_req_en = 1'b1; bus.ic_req_addr = 20'h05670;
    @(negedge clk);
    bus.ic_req_en = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({busy, err, bus.ic_ack, bus.dc_ack, bus.ic_rsp_en, bus.dc_rsp_en, bus.mem_ren, bus.mem_wen} !== 8'h00) begin
      n_fail++; $display("FAIL t6_ctrl: got %b expected 00000000", {busy, err, bus.ic_ack, bus.dc_ack, bus.ic_rsp_en, bus.dc_rsp_en, bus.mem_ren, bus.mem_wen});
    end
    n_checks++;
    if ({bus.ic_rsp_line, bus.dc_rsp_line} !== 256'h0) begin
      n_fail++; $display("FAIL t6_lines: ic=%h dc=%h expected 0", bus.ic_rsp_line, bus.dc_rsp_line);
    end
    rst = 1'b0;
    bad = 1'b0;
    repeat (8) begin @(negedge clk); bad |= bus.ic_rsp_en | bus.dc_rsp_en | busy | bus.mem_ren; end
    n_checks++;
    if (bad !== 1'b0) begin n_fail++; $display("FAIL t6_late: activity after reset=%b expected 0", bad); end
    stub_delay = 1;
    run_read_ic(20'h01230, "t6_after");
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_basic();
    test_round_robin();
    test_wb_rd();
    test_wb_only();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
